page_readback_mux: RTL and testbench

- Readback page multiplexer feeding the `data_ib32` input of the return-path serial register in the MCOI application.
- Captures a new page number whenever the forward serial register raises `newdata`.
- Selects one of `G_NPAGES` 32-bit status sources and holds it for `G_SETTLE` cycles. It then samples the source on a GBT frame-valid slot and presents a stable registered word to the serial transmitter.
- Covers the rx_frameclk domain, replacing the ad-hoc page case statement.

---
 rtl/ckrs_pkg.sv | 8 +
 rtl/page_readback_mux.sv | 155 +++++++++++++++
 tb/tb_page_readback_mux.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ckrs_pkg.sv
// Clock/reset bundle shared by the rx_frameclk-domain blocks.
// Reset is asynchronous and active-high.
package ckrs_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
endpackage

// File: rtl/page_readback_mux.sv
// Readback page multiplexer feeding the return-path serial register data input.
// Define PAGE_MUX_ECHO_EN to tag every loaded word with the answering page in [31:24].
module page_readback_mux
  import ckrs_pkg::*;
#(
  parameter int          G_NPAGES  = 32,
  parameter int          G_SETTLE  = 2,
  parameter int          G_TIMEOUT = 1024,
  parameter logic [31:0] G_DEFAULT = 32'hDEADBEEF
) (
  input  ckrs_t                  ClkRs_ix,
  input  logic                   newdata_i,
  input  logic [31:0]            page_selector_ib32,
  input  logic                   tx_valid_i,
  input  logic [G_NPAGES*32-1:0] page_data_ib,
  input  logic [G_NPAGES-1:0]    page_valid_ib,
  input  logic                   clear_i,
  output logic [31:0]            data_ob32,
  output logic                   data_valid_o,
  output logic [7:0]             page_ob8,
  output logic                   busy_o,
  output logic                   range_err_o,
  output logic                   timeout_err_o
);

  localparam int SW = (G_SETTLE > 0) ? $clog2(G_SETTLE + 1) : 1;
  localparam int TW = (G_TIMEOUT > 1) ? $clog2(G_TIMEOUT) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LATCH  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] SAMPLE = 2'd3;

  logic          clk;
  logic          rst;
  logic [1:0]    state;
  logic [7:0]    req_page;
  logic          req_frz;
  logic          pend;
  logic          frz;
  logic          oor;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic [31:0]   src;
  logic          src_ok;
  logic          take;
  logic          tmo;
  logic          done;
  logic [31:0]   load_raw;
  logic [31:0]   load_word;
  logic          unused_sel;

  assign clk        = ClkRs_ix.clk;
  assign rst        = ClkRs_ix.reset;
  assign unused_sel = ^page_selector_ib32[30:8];
  assign busy_o     = (state != IDLE);

  always_comb begin
    src    = '0;
    src_ok = 1'b0;
    for (int i = 0; i < G_NPAGES; i++) begin
      if (page_ob8 == 8'(i)) begin
        src    = page_data_ib[32*i +: 32];
        src_ok = page_valid_ib[i];
      end
    end
  end

  // an out-of-range page only waits for a frame slot, not a source valid
  assign take     = oor ? tx_valid_i : (tx_valid_i && src_ok);
  assign tmo      = !take && (tcnt == TW'(G_TIMEOUT - 1));
  assign done     = (state == SAMPLE) && (take || tmo);
  assign load_raw = (take && !oor) ? src : G_DEFAULT;

`ifdef PAGE_MUX_ECHO_EN
  assign load_word = {page_ob8, load_raw[23:0]};
`else
  assign load_word = load_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_page     <= '0;
      req_frz      <= 1'b0;
      pend         <= 1'b0;
      frz          <= 1'b0;
      oor          <= 1'b0;
      scnt         <= '0;
      tcnt         <= '0;
      page_ob8     <= '0;
      data_ob32    <= 32'h00000001;
      data_valid_o <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      if (newdata_i) begin
        req_page <= page_selector_ib32[7:0];
        req_frz  <= page_selector_ib32[31];
      end
      unique case (state)
        IDLE: begin
          if (newdata_i || pend) begin
            state <= LATCH;
            pend  <= 1'b0;
          end
        end
        LATCH: begin
          if (!newdata_i) begin
            page_ob8 <= req_page;
            frz      <= req_frz;
            oor      <= {24'd0, req_page} >= 32'(G_NPAGES);
            scnt     <= SW'(G_SETTLE);
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (newdata_i) begin
            state <= LATCH;
          end else if (scnt <= SW'(1)) begin
            tcnt  <= '0;
            state <= SAMPLE;
          end else begin
            scnt <= scnt - 1'b1;
          end
        end
        SAMPLE: begin
          if (newdata_i) pend <= 1'b1;
          if (done) begin
            state <= IDLE;
            if (!frz) begin
              data_ob32    <= load_word;
              data_valid_o <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_err_o   <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      if (done && take && oor) range_err_o <= 1'b1;
      else if (clear_i)        range_err_o <= 1'b0;
      if (done && tmo)         timeout_err_o <= 1'b1;
      else if (clear_i)        timeout_err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_page_readback_mux.sv
// Randomized bench for page_readback_mux against a transaction-level model.
// Each request's result and pulse cycle are predicted from the tx_valid pattern.
module tb_page_readback_mux;
  import ckrs_pkg::*;

  localparam int NP = 32;
  localparam int TO = 1024;
  localparam logic [31:0] DEF = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ckrs_t ckrs;
  logic newdata = 1'b0;
  logic [31:0] sel = '0;
  logic tx_valid = 1'b0;
  logic [NP*32-1:0] page_data = '1;
  logic [NP-1:0] page_valid = '1;
  logic clear = 1'b0;
  logic [31:0] dout;
  logic dvalid;
  logic [7:0] page;
  logic busy;
  logic rerr;
  logic terr;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_data = 32'h00000001;
  logic m_rerr = 1'b0;
  logic m_terr = 1'b0;
  logic txp [0:1100];

  always #5 clk = ~clk;
  assign ckrs.clk = clk;
  assign ckrs.reset = rst;

  page_readback_mux dut (
    .ClkRs_ix(ckrs),
    .newdata_i(newdata),
    .page_selector_ib32(sel),
    .tx_valid_i(tx_valid),
    .page_data_ib(page_data),
    .page_valid_ib(page_valid),
    .clear_i(clear),
    .data_ob32(dout),
    .data_valid_o(dvalid),
    .page_ob8(page),
    .busy_o(busy),
    .range_err_o(rerr),
    .timeout_err_o(terr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] shape(input logic [7:0] pg,
                                        input logic [31:0] w);
`ifdef PAGE_MUX_ECHO_EN
    return {pg, w[23:0]};
`else
    return w;
`endif
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_data"}, dout, m_data);
    chk({tag, "_rerr"}, 32'(rerr), 32'(m_rerr));
    chk({tag, "_terr"}, 32'(terr), 32'(m_terr));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Request issued at cycle 0; SAMPLE occupies cycles 4..4+TO-1.
  task automatic run_req(input logic [31:0] word, input int txpct,
                         output int pcyc);
    int hit, evt, npulse, pi;
    logic [31:0] pdata, exp_word;
    logic [7:0] pg;
    bit oor, frz, ok;
    pg = word[7:0];
    pi = int'(pg);
    oor = (pi >= NP);
    frz = word[31];
    ok = oor ? 1'b1 : page_valid[pi % NP];
    for (int k = 0; k <= 1100; k++)
      txp[k] = ($urandom_range(0, 99) < txpct);
    hit = -1;
    for (int k = 4; k < 4 + TO; k++)
      if (hit < 0 && txp[k] && ok) hit = k;
    evt = (hit < 0) ? 4 + TO : hit + 1;
    if (hit < 0 || oor) exp_word = shape(pg, DEF);
    else exp_word = shape(pg, page_data[32*pi +: 32]);
    if (!frz) m_data = exp_word;
    if (hit >= 0 && oor) m_rerr = 1'b1;
    if (hit < 0) m_terr = 1'b1;
    npulse = 0;
    pcyc = -1;
    pdata = '0;
    for (int k = 0; k <= evt + 2; k++) begin
      @(negedge clk);
      if (dvalid) begin
        npulse++;
        if (pcyc < 0) begin
          pcyc = k;
          pdata = dout;
        end
      end
      newdata = (k == 0);
      sel = word;
      tx_valid = txp[k];
    end
    tx_valid = 1'b0;
    chk("req_npulse", 32'(npulse), frz ? 32'd0 : 32'd1);
    if (!frz) begin
      chk("req_cycle", 32'(pcyc), 32'(evt));
      chk("req_pdata", pdata, exp_word);
    end
    chk("req_page", 32'(page), 32'(pg));
    check_state("req");
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_rerr = 1'b0;
    m_terr = 1'b0;
    chk("clr_rerr", 32'(rerr), 32'd0);
    chk("clr_terr", 32'(terr), 32'd0);
  endtask

  initial begin
    int pc, np, vcount;
    logic [31:0] w;
    // reset with all-ones sources
    repeat (3) @(negedge clk);
    chk("rst_data", dout, 32'h00000001);
    chk("rst_valid", 32'(dvalid), 32'd0);
    chk("rst_page", 32'(page), 32'd0);
    chk("rst_flags", {30'd0, rerr, terr}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    vcount = 0;
    repeat (100) begin
      @(negedge clk);
      if (dvalid) vcount++;
    end
    chk("idle_novalid", 32'(vcount), 32'd0);

    // page 3 latency
    page_valid = '1;
    page_data[3*32 +: 32] = 32'hCAFE0003;
    run_req(32'd3, 100, pc);
    chk("lat5", 32'(pc), 32'd5);
`ifdef PAGE_MUX_ECHO_EN
    chk("cafe", dout, 32'h03FE0003);
`else
    chk("cafe", dout, 32'hCAFE0003);
`endif

    // out-of-range page
    run_req(32'd40, 100, pc);
    chk("oor_rerr", 32'(rerr), 32'd1);
    repeat (5) @(negedge clk);
    chk("oor_sticky", 32'(rerr), 32'd1);
    do_clear();

    // timeout
    page_valid[1] = 1'b0;
    run_req(32'd1, 100, pc);
    chk("tmo_terr", 32'(terr), 32'd1);
    page_valid[1] = 1'b1;
    do_clear();

    // freeze
    run_req(32'h80000002, 100, pc);

    // pending: 5 sampled, 4 overwritten by 6
    page_data[4*32 +: 32] = 32'h44440004;
    page_data[5*32 +: 32] = 32'h55550005;
    page_data[6*32 +: 32] = 32'h66660006;
    np = 0;
    for (int k = 0; k <= 25; k++) begin
      @(negedge clk);
      if (dvalid) begin
        if (np == 0) begin
          chk("pend_d1", dout, shape(8'd5, 32'h55550005));
          chk("pend_t1", 32'(k), 32'd11);
        end else begin
          chk("pend_d2", dout, shape(8'd6, 32'h66660006));
          chk("pend_t2", 32'(k), 32'd16);
        end
        np++;
      end
      newdata = (k == 0 || k == 6 || k == 8);
      sel = (k == 0) ? 32'd5 : (k == 6) ? 32'd4 : 32'd6;
      tx_valid = (k >= 10);
    end
    tx_valid = 1'b0;
    newdata = 1'b0;
    chk("pend_cnt", 32'(np), 32'd2);
    m_data = shape(8'd6, 32'h66660006);
    check_state("pend");

    // reset mid-operation
    @(negedge clk);
    newdata = 1'b1;
    sel = 32'd7;
    @(negedge clk);
    newdata = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    m_data = 32'h00000001;
    m_rerr = 1'b0;
    m_terr = 1'b0;
    check_state("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_idle", 32'(busy), 32'd0);

    // randomized requests
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NP; i++) page_data[32*i +: 32] = $urandom;
      page_valid = $urandom;
      w = 32'($urandom_range(0, 39));
      if (w < NP) page_valid[w[4:0]] = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) w[31] = 1'b1;
      run_req(w, $urandom_range(10, 100), pc);
      if ($urandom_range(0, 3) == 0) do_clear();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
